matmul_sequencer: RTL and testbench
===================================

// Module: matmul_sequencer
// PURPOSE
//  Control engine for the AI accelerator's matrix-multiply operation.
//  After the Wishbone front end sets op/dims and pulses start, it walks i/j/k over the A and B buffers.
//  It performs a signed multiply-accumulate per element and writes each result into the C buffer.
//  Sits between the WB register file and the A/B/C matrix RAMs.
// PARAMETERS
//  SEQ_BITS  4   index width per dimension; max matrix dim = 2**SEQ_BITS (16)
//  DATA_W    32  element / accumulator width, two's complement
// PORTS
//  wb_clk_i   in   1            clock, all logic on rising edge
//  wb_rst_i   in   1            reset, synchronous, active-low
//  start      in   1            1-cycle request to run; sampled only in IDLE
//  op         in   DATA_W       operation code; only 1 (multiply) valid
//  w_a,h_a    in   SEQ_BITS+1   A width (cols) / height (rows)
//  w_b,h_b    in   SEQ_BITS+1   B width / height
//  busy       out  1            high whenever state != IDLE
//  done       out  1            1-cycle pulse, C fully written
//  err        out  1            1-cycle pulse, request rejected
//  a_addr     out  2*SEQ_BITS   {row,col} of A read
//  a_rd_data  in   DATA_W       A data, valid 1 cycle after a_addr
//  b_addr     out  2*SEQ_BITS   {row,col} of B read
//  b_rd_data  in   DATA_W       B data, valid 1 cycle after b_addr
//  c_we       out  1            C write strobe, 1 cycle per element
//  c_addr     out  2*SEQ_BITS   {row,col} of C write
//  c_wr_data  out  DATA_W       C element value
// BEHAVIOUR
//  Reset (wb_rst_i==0 at a clock edge):
//   - state=IDLE; i,j,k,acc=0.
//   - All outputs 0; any run in progress aborts with no further c_we.
//  IDLE:
//   - start=1 -> latch op/dims, go to CHECK.
//   - Dims/op inputs are ignored outside IDLE.
//  CHECK (1 cycle):
//   - Pass: op==1, all dims in 1..2**SEQ_BITS, w_a==h_b.
//   - Pass -> i=j=k=0, acc=0, go to FETCH.
//   - Fail -> err=1 this cycle, back to IDLE; no c_we ever issued.
//  FETCH:
//   - Drive a_addr={i,k}, b_addr={k,j}; go to MAC.
//  MAC:
//   - acc <= acc + $signed(a_rd_data)*$signed(b_rd_data).
//   - Product and sum truncated to DATA_W LSBs (wraps, no saturation).
//   - If k==w_a-1 -> WRITE; else k++ and go to FETCH.
//  WRITE (1 cycle):
//   - c_we=1, c_addr={i,j}, c_wr_data=final acc; then acc=0, k=0.
//   - If j<w_b-1: j++ -> FETCH.
//   - Else if i<h_a-1: j=0, i++ -> FETCH.
//   - Else -> DONE.
//   - C order is row-major (j fastest).
//  DONE (1 cycle):
//   - done=1, then IDLE.
//  Latency:
//   - done is high exactly 2 + h_a*w_b*(2*w_a+1) cycles after the edge that samples start.
//  Boundaries:
//   - start while busy is ignored, not queued.
//   - 1x1 matrices are legal.
//   - Max dim (16) indexes fully; no address wrap.
//   - a_addr/b_addr/c_addr hold their last value outside active states.
// TESTING
//  - 2x2: A=[-3,-15;-6,7], B=[9,-15;-2,-5], start -> C writes
//    (0,0)=3, (0,1)=120, (1,0)=-68, (1,1)=55 in that order; done 22 cycles after start.
//  - 1x1: A=5, B=-7 -> single c_we, C(0,0)=-35; done 5 cycles after start.
//  - w_a=2, h_b=3 (or op=2, or any dim=0 or 17) -> err pulse at CHECK, busy 1 cycle, zero c_we, no done.
//  - Overflow: 1x1 A=0x7FFFFFFF, B=2 -> C=0xFFFFFFFE (wrapped).
//  - 16x16 identity times random B -> C==B (256 writes); done at 2+256*33=8450 cycles.
//  - Reset low mid-run (after 3rd c_we), then restart 2x2 test:
//    outputs 0 during reset, no stray writes, second run gives correct C.
//  - start pulsed again while busy -> ignored; exactly one done.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Sequencer for C = A * B: walks i/j/k over the A/B RAMs, accumulates a signed
// dot product per C element and writes C in row-major order.
module matmul_sequencer #(
    parameter int SEQ_BITS = 4,
    parameter int DATA_W   = 32
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    start,
    input  logic [DATA_W-1:0]       op,
    input  logic [SEQ_BITS:0]       w_a,
    input  logic [SEQ_BITS:0]       h_a,
    input  logic [SEQ_BITS:0]       w_b,
    input  logic [SEQ_BITS:0]       h_b,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [2*SEQ_BITS-1:0]   a_addr,
    input  logic [DATA_W-1:0]       a_rd_data,
    output logic [2*SEQ_BITS-1:0]   b_addr,
    input  logic [DATA_W-1:0]       b_rd_data,
    output logic                    c_we,
    output logic [2*SEQ_BITS-1:0]   c_addr,
    output logic [DATA_W-1:0]       c_wr_data
);

    localparam int                  MAX_DIM_I = 2 ** SEQ_BITS;
    localparam logic [SEQ_BITS:0]   MAX_DIM   = MAX_DIM_I[SEQ_BITS:0];
    localparam logic [SEQ_BITS:0]   DIM_ONE   = (SEQ_BITS + 1)'(1);
    localparam logic [SEQ_BITS-1:0] IDX_ZERO  = '0;
    localparam logic [SEQ_BITS-1:0] IDX_ONE   = SEQ_BITS'(1);
    localparam logic [DATA_W-1:0]   OP_MUL    = DATA_W'(1);

    // dimension slots: 0 = w_a, 1 = h_a, 2 = w_b, 3 = h_b
    localparam int D_WA = 0;
    localparam int D_HA = 1;
    localparam int D_WB = 2;
    localparam int D_HB = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [DATA_W-1:0]      op_reg;
    logic [SEQ_BITS:0]      dim_in  [4];
    logic [SEQ_BITS:0]      dim_reg [4];
    logic [3:0]             dim_ok;
    logic                   check_pass;

    logic [SEQ_BITS-1:0]    i_reg, i_next;
    logic [SEQ_BITS-1:0]    j_reg, j_next;
    logic [SEQ_BITS-1:0]    k_reg, k_next;
    logic [SEQ_BITS-1:0]    i_inc, j_inc, k_inc;
    logic                   last_i, last_j, last_k;

    logic [DATA_W-1:0]      acc_reg, acc_next;
    logic [DATA_W-1:0]      prod;
    logic [DATA_W-1:0]      acc_sum;

    logic [2*SEQ_BITS-1:0]  a_addr_reg, a_addr_next;
    logic [2*SEQ_BITS-1:0]  b_addr_reg, b_addr_next;
    logic [2*SEQ_BITS-1:0]  c_addr_reg, c_addr_next;
    logic [DATA_W-1:0]      c_wr_data_reg, c_wr_data_next;
    logic                   c_we_reg, c_we_next;
    logic                   done_reg, done_next;
    logic                   err_next;

    assign dim_in[D_WA] = w_a;
    assign dim_in[D_HA] = h_a;
    assign dim_in[D_WB] = w_b;
    assign dim_in[D_HB] = h_b;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dim_ok
            assign dim_ok[gi] = (dim_reg[gi] != '0) && (dim_reg[gi] <= MAX_DIM);
        end
    endgenerate

    assign check_pass = (&dim_ok) && (op_reg == OP_MUL) && (dim_reg[D_WA] == dim_reg[D_HB]);

    assign i_inc  = i_reg + IDX_ONE;
    assign j_inc  = j_reg + IDX_ONE;
    assign k_inc  = k_reg + IDX_ONE;
    // Compare in SEQ_BITS+1 width so a dimension of 2**SEQ_BITS ends at index 2**SEQ_BITS-1
    assign last_k = ({1'b0, k_reg} == (dim_reg[D_WA] - DIM_ONE));
    assign last_j = ({1'b0, j_reg} == (dim_reg[D_WB] - DIM_ONE));
    assign last_i = ({1'b0, i_reg} == (dim_reg[D_HA] - DIM_ONE));

    // Low DATA_W bits of the product are identical for signed and unsigned operands
    assign prod    = DATA_W'($signed(a_rd_data) * $signed(b_rd_data));
    assign acc_sum = acc_reg + prod;

    always_comb begin
        state_next     = state_reg;
        i_next         = i_reg;
        j_next         = j_reg;
        k_next         = k_reg;
        acc_next       = acc_reg;
        a_addr_next    = a_addr_reg;
        b_addr_next    = b_addr_reg;
        c_addr_next    = c_addr_reg;
        c_wr_data_next = c_wr_data_reg;
        c_we_next      = 1'b0;
        done_next      = 1'b0;
        err_next       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (check_pass) begin
                    i_next      = IDX_ZERO;
                    j_next      = IDX_ZERO;
                    k_next      = IDX_ZERO;
                    acc_next    = '0;
                    a_addr_next = '0;
                    b_addr_next = '0;
                    state_next  = S_FETCH;
                end else begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_FETCH: begin
                state_next = S_MAC;
            end
            S_MAC: begin
                acc_next = acc_sum;
                if (last_k) begin
                    c_we_next      = 1'b1;
                    c_addr_next    = {i_reg, j_reg};
                    c_wr_data_next = acc_sum;
                    state_next     = S_WRITE;
                end else begin
                    k_next      = k_inc;
                    a_addr_next = {i_reg, k_inc};
                    b_addr_next = {k_inc, j_reg};
                    state_next  = S_FETCH;
                end
            end
            S_WRITE: begin
                acc_next = '0;
                k_next   = IDX_ZERO;
                if (!last_j) begin
                    j_next      = j_inc;
                    a_addr_next = {i_reg, IDX_ZERO};
                    b_addr_next = {IDX_ZERO, j_inc};
                    state_next  = S_FETCH;
                end else if (!last_i) begin
                    j_next      = IDX_ZERO;
                    i_next      = i_inc;
                    a_addr_next = {i_inc, IDX_ZERO};
                    b_addr_next = {IDX_ZERO, IDX_ZERO};
                    state_next  = S_FETCH;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_reg     <= S_IDLE;
            op_reg        <= '0;
            i_reg         <= '0;
            j_reg         <= '0;
            k_reg         <= '0;
            acc_reg       <= '0;
            a_addr_reg    <= '0;
            b_addr_reg    <= '0;
            c_addr_reg    <= '0;
            c_wr_data_reg <= '0;
            c_we_reg      <= 1'b0;
            done_reg      <= 1'b0;
            for (int d = 0; d < 4; d++) begin
                dim_reg[d] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            i_reg         <= i_next;
            j_reg         <= j_next;
            k_reg         <= k_next;
            acc_reg       <= acc_next;
            a_addr_reg    <= a_addr_next;
            b_addr_reg    <= b_addr_next;
            c_addr_reg    <= c_addr_next;
            c_wr_data_reg <= c_wr_data_next;
            c_we_reg      <= c_we_next;
            done_reg      <= done_next;
            // Request is captured only when idle; inputs are don't-care while running
            if (state_reg == S_IDLE && start) begin
                op_reg <= op;
                for (int d = 0; d < 4; d++) begin
                    dim_reg[d] <= dim_in[d];
                end
            end
        end
    end

    assign busy      = (state_reg != S_IDLE);
    assign err       = err_next;
    assign done      = done_reg;
    assign a_addr    = a_addr_reg;
    assign b_addr    = b_addr_reg;
    assign c_we      = c_we_reg;
    assign c_addr    = c_addr_reg;
    assign c_wr_data = c_wr_data_reg;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: RAM models for A/B, a scoreboard of expected C
// writes built by plain nested-loop matrix multiply, and per-cycle output checks.
module tb_matmul_sequencer;

    localparam int SB = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] op = '0;
    logic [SB:0]   w_a = '0, h_a = '0, w_b = '0, h_b = '0;
    logic          busy, done, err, c_we;
    logic [2*SB-1:0] a_addr, b_addr, c_addr;
    logic [DW-1:0] a_rd_data = '0, b_rd_data = '0, c_wr_data;

    matmul_sequencer #(.SEQ_BITS(SB), .DATA_W(DW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .start(start), .op(op),
        .w_a(w_a), .h_a(h_a), .w_b(w_b), .h_b(h_b),
        .busy(busy), .done(done), .err(err),
        .a_addr(a_addr), .a_rd_data(a_rd_data),
        .b_addr(b_addr), .b_rd_data(b_rd_data),
        .c_we(c_we), .c_addr(c_addr), .c_wr_data(c_wr_data)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_a [16][16];
    logic [DW-1:0] mem_b [16][16];

    always @(posedge clk) begin
        a_rd_data <= mem_a[a_addr[7:4]][a_addr[3:0]];
        b_rd_data <= mem_b[b_addr[7:4]][b_addr[3:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] val;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  exp_done_cyc = -1;
    int  exp_err_cyc  = -1;
    int  errors = 0;
    int  checks = 0;
    int  done_count = 0;
    int  we_count = 0;
    bit  in_reset = 1'b0;

    // Per-cycle compare of DUT outputs against the scoreboard
    always @(negedge clk) begin
        if (in_reset) begin
            checks++;
            if (busy || done || err || c_we || a_addr != 0 || b_addr != 0 || c_addr != 0 || c_wr_data != 0) begin
                errors++;
                $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b c_we=%0b a=%h b=%h c=%h d=%h, required all 0",
                         busy, done, err, c_we, a_addr, b_addr, c_addr, c_wr_data);
            end
        end else begin
            if (c_we) begin
                we_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stray_write: c_addr=%h data=%h at cyc %0d, no write expected", c_addr, c_wr_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (c_addr !== e.addr || c_wr_data !== e.val) begin
                        errors++;
                        $display("FAIL c_write: got addr=%h data=%h, required addr=%h data=%h", c_addr, c_wr_data, e.addr, e.val);
                    end else begin
                        $display("write ok: C(%0d,%0d)=%0d", e.addr[7:4], e.addr[3:0], $signed(e.val));
                    end
                end
            end
            if (done || (exp_done_cyc != -1 && cyc >= exp_done_cyc)) begin
                checks++;
                if (done) done_count++;
                if (!(done && cyc == exp_done_cyc && exp_q.size() == 0)) begin
                    errors++;
                    $display("FAIL done_pulse: done=%0b at cyc %0d pending_writes=%0d, required done at cyc %0d",
                             done, cyc, exp_q.size(), exp_done_cyc);
                end else begin
                    $display("done ok at cyc %0d", cyc);
                end
                exp_done_cyc = -1;
            end
            if (err || (exp_err_cyc != -1 && cyc >= exp_err_cyc)) begin
                checks++;
                if (!(err && busy && cyc == exp_err_cyc)) begin
                    errors++;
                    $display("FAIL err_pulse: err=%0b busy=%0b at cyc %0d, required err at cyc %0d",
                             err, busy, cyc, exp_err_cyc);
                end else begin
                    $display("err ok at cyc %0d", cyc);
                end
                exp_err_cyc = -1;
            end
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Issue one request; the model decides legality and builds the expected C stream
    task automatic launch(input logic [31:0] op_v, input int ha, input int wa,
                          input int hb, input int wb, output int s);
        bit legal;
        logic [31:0] acc;
        wr_t w;
        @(negedge clk);
        op = op_v; h_a = 5'(ha); w_a = 5'(wa); h_b = 5'(hb); w_b = 5'(wb);
        start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        legal = (op_v == 1) && ha >= 1 && ha <= 16 && wa >= 1 && wa <= 16 &&
                hb >= 1 && hb <= 16 && wb >= 1 && wb <= 16 && wa == hb;
        if (legal) begin
            for (int r = 0; r < ha; r++) begin
                for (int c = 0; c < wb; c++) begin
                    acc = 0;
                    for (int kk = 0; kk < wa; kk++) acc = acc + mem_a[r][kk] * mem_b[kk][c];
                    w.addr = {4'(r), 4'(c)};
                    w.val  = acc;
                    exp_q.push_back(w);
                end
            end
            exp_done_cyc = s + 2 + ha * wb * (2 * wa + 1);
        end else begin
            exp_err_cyc = s;
        end
        check("busy_after_start", busy, 1);
        @(negedge clk);
        start = 1'b0;
        // Inputs must be ignored once the request is captured
        op = $urandom; h_a = 5'($urandom); w_a = 5'($urandom); h_b = 5'($urandom); w_b = 5'($urandom);
        if (!legal) begin
            @(posedge clk);
            #1;
            check("busy_one_cycle_on_err", busy, 0);
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget && (exp_done_cyc != -1 || exp_err_cyc != -1); n++) @(negedge clk);
        if (exp_done_cyc != -1 || exp_err_cyc != -1) begin
            checks++;
            errors++;
            $display("FAIL timeout: run did not finish within %0d cycles", budget);
            exp_done_cyc = -1;
            exp_err_cyc = -1;
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic load_2x2();
        mem_a[0][0] = -3; mem_a[0][1] = -15; mem_a[1][0] = -6; mem_a[1][1] = 7;
        mem_b[0][0] = 9;  mem_b[0][1] = -15; mem_b[1][0] = -2; mem_b[1][1] = -5;
    endtask

    initial begin
        int s, ha, wa, wb, base, dc;
        int lit2[4];
        lit2 = '{3, 120, -68, 55};
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                mem_a[r][c] = 0;
                mem_b[r][c] = 0;
            end

        // Reset
        rst_n = 1'b0;
        @(posedge clk); #1; in_reset = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1; in_reset = 1'b0;

        // 2x2 with hand-computed C
        load_2x2();
        launch(1, 2, 2, 2, 2, s);
        for (int n = 0; n < 4; n++) check("model_2x2_c", $signed(exp_q[n].val), lit2[n]);
        check("model_2x2_latency", exp_done_cyc - s, 22);
        wait_idle(40);

        // 1x1
        mem_a[0][0] = 5; mem_b[0][0] = -7;
        launch(1, 1, 1, 1, 1, s);
        check("model_1x1_c", $signed(exp_q[0].val), -35);
        check("model_1x1_latency", exp_done_cyc - s, 5);
        wait_idle(20);

        // Overflow wraps
        mem_a[0][0] = 32'h7FFF_FFFF; mem_b[0][0] = 2;
        launch(1, 1, 1, 1, 1, s);
        check("model_overflow", exp_q[0].val, 32'hFFFF_FFFE);
        wait_idle(20);

        // Rejected requests
        base = we_count; dc = done_count;
        launch(1, 2, 2, 3, 2, s); wait_idle(10);
        launch(2, 2, 2, 2, 2, s); wait_idle(10);
        launch(1, 0, 2, 2, 2, s); wait_idle(10);
        launch(1, 2, 2, 2, 17, s); wait_idle(10);
        launch(1, 2, 17, 17, 2, s); wait_idle(10);
        check("no_write_on_err", we_count - base, 0);
        check("no_done_on_err", done_count - dc, 0);

        // Random legal and illegal runs
        for (int t = 0; t < 10; t++) begin
            ha = $urandom_range(1, 5); wa = $urandom_range(1, 5); wb = $urandom_range(1, 5);
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) begin
                    mem_a[r][c] = $urandom;
                    mem_b[r][c] = (t % 2 == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
                end
            if (t % 4 == 3) launch(1, ha, wa, wa + 1, wb, s);
            else            launch(1, ha, wa, wa, wb, s);
            wait_idle(300);
        end

        // 16x16 identity times random B
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                mem_a[r][c] = (r == c) ? 1 : 0;
                mem_b[r][c] = $urandom;
            end
        base = we_count;
        launch(1, 16, 16, 16, 16, s);
        check("model_identity_latency", exp_done_cyc - s, 8450);
        wait_idle(8500);
        check("identity_write_count", we_count - base, 256);

        // Reset after the third write, then rerun 2x2
        load_2x2();
        base = we_count;
        launch(1, 2, 2, 2, 2, s);
        for (int n = 0; n < 40 && we_count < base + 3; n++) @(negedge clk);
        check("writes_before_reset", we_count - base, 3);
        rst_n = 1'b0;
        exp_q.delete();
        exp_done_cyc = -1;
        @(posedge clk); #1; in_reset = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1; in_reset = 1'b0;
        repeat (10) @(negedge clk);
        check("no_write_after_reset", we_count - base, 3);
        launch(1, 2, 2, 2, 2, s);
        wait_idle(40);

        // Start while busy is ignored
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                mem_a[r][c] = $urandom_range(0, 50);
                mem_b[r][c] = $urandom_range(0, 50);
            end
        dc = done_count;
        launch(1, 3, 3, 3, 3, s);
        repeat (4) @(negedge clk);
        op = 1; h_a = 1; w_a = 1; h_b = 1; w_b = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(100);
        repeat (20) @(negedge clk);
        check("single_done_when_restarted_busy", done_count - dc, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
